// File: rtl/mult_pkg.sv
// Shared constants for the 64x64 multiplier datapath: default widths, the
// serializer state encoding and a constant-foldable clog2.
package mult_pkg;

    localparam int PROD_W_DEF = 128;
    localparam int WORD_W_DEF = 32;

    // Serializer state encoding (1-bit, legacy-compatible constants)
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // Ceiling log2, never below 1 so a counter always has at least one bit
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Number of output words per product
    function automatic int nbeats(input int prod_w, input int word_w);
        return prod_w / word_w;
    endfunction

endpackage

// File: rtl/word_mux.sv
// Combinational word selector: picks one WORD_W slice of a wide register by
// beat index, optionally counting from the most-significant end.
module word_mux
    import mult_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int WORD_W    = WORD_W_DEF,
    parameter int MSW_FIRST = 0,
    parameter int IDX_W     = clog2(nbeats(PROD_W, WORD_W))
) (
    input  logic [PROD_W-1:0] data,
    input  logic [IDX_W-1:0]  idx,
    output logic [WORD_W-1:0] word
);

    localparam int NB = nbeats(PROD_W, WORD_W);

    logic [NB-1:0][WORD_W-1:0] words;
    logic [IDX_W-1:0]          sel;

    assign words = data;

    // Map beat number to physical word position, then select it
    always_comb begin
        sel = idx;
        if (MSW_FIRST != 0) sel = IDX_W'(NB - 1) - idx;
        word = words[sel];
    end

endmodule

// File: rtl/product_serializer.sv
// Captures a registered 128-bit product on a valid/ready handshake and emits
// it as NBEATS narrower words with a last-beat flag. A new product can be
// taken on the same cycle the final word of the previous one is accepted,
// so back-to-back products stream with no bubble.
module product_serializer
    import mult_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int WORD_W    = WORD_W_DEF,
    parameter int MSW_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int NBEATS = nbeats(PROD_W, WORD_W);
    localparam int BW     = clog2(NBEATS);

    logic [0:0]        state;
    logic [BW-1:0]     beat;
    logic [PROD_W-1:0] hold;
    logic [WORD_W-1:0] mux_word;
    logic              in_acc;
    logic              out_acc;

    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_last  = out_valid && (beat == BW'(NBEATS - 1));
    // In SEND the slot frees up only as the final word leaves
    assign in_ready  = (state == IDLE) || (out_valid && out_ready && out_last);
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;

    word_mux #(
        .PROD_W    (PROD_W),
        .WORD_W    (WORD_W),
        .MSW_FIRST (MSW_FIRST),
        .IDX_W     (BW)
    ) u_word_mux (
        .data (hold),
        .idx  (beat),
        .word (mux_word)
    );

    // Idle presents the bottom word of the holding register
    assign out_data = out_valid ? mux_word : hold[WORD_W-1:0];

    // FSM, beat counter and holding register; stalls simply hold everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= '0;
            hold  <= '0;
        end else if (in_acc) begin
            hold  <= in_data;
            beat  <= '0;
            state <= SEND;
        end else if (out_acc) begin
            if (out_last) begin
                state <= IDLE;
                beat  <= '0;
            end else begin
                beat <= beat + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_product_serializer.sv
// Bench for product_serializer: two instances (LSW-first and MSW-first)
// share one stimulus. Directed table vectors and hand sequences cover the
// corner cases; a queue-based reference model checks every cycle.
module tb_product_serializer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_data;
    logic         out_ready;

    logic        in_ready0, out_valid0, out_last0, busy0;
    logic [31:0] out_data0;
    logic        in_ready1, out_valid1, out_last1, busy1;
    logic [31:0] out_data1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    product_serializer #(.PROD_W(128), .WORD_W(32), .MSW_FIRST(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_last(out_last0), .busy(busy0)
    );

    product_serializer #(.PROD_W(128), .WORD_W(32), .MSW_FIRST(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_last(out_last1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each queue holds the words of the current product still to be sent,
    // in emission order. Head = word on the bus; size 1 = last beat.
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    function automatic logic [31:0] word_of(input logic [127:0] p, input int i);
        return p[i*32 +: 32];
    endfunction

    function automatic bit model_ready(input int n, input logic ordy);
        return (n == 0) || (ordy && n == 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            bit rdy;
            rdy = model_ready(q0.size(), out_ready);
            if (out_ready && q0.size() > 0) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (in_valid && rdy) begin
                for (int i = 0; i < 4; i++) begin
                    q0.push_back(word_of(in_data, i));
                    q1.push_back(word_of(in_data, 3 - i));
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("m_in_ready0",  in_ready0,  model_ready(q0.size(), out_ready));
            chk("m_in_ready1",  in_ready1,  model_ready(q1.size(), out_ready));
            chk("m_out_valid0", out_valid0, q0.size() > 0);
            chk("m_out_valid1", out_valid1, q1.size() > 0);
            chk("m_busy0",      busy0,      q0.size() > 0);
            chk("m_busy1",      busy1,      q1.size() > 0);
            chk("m_out_last0",  out_last0,  q0.size() == 1);
            chk("m_out_last1",  out_last1,  q1.size() == 1);
            if (q0.size() > 0) chk("m_out_data0", out_data0, q0[0]);
            if (q1.size() > 0) chk("m_out_data1", out_data1, q1[0]);
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [127:0]      prod;
        logic [3:0][31:0]  lsw;  // [k] = k-th word emitted, LSW-first
        logic [3:0][31:0]  msw;  // [k] = k-th word emitted, MSW-first
    } vec_t;

    vec_t tbl[3];

    // Present one product for a single cycle from idle, then check its 4 beats
    task automatic send_vec(input int t);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = tbl[t].prod;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d_data0_b%0d", t, k), out_data0, tbl[t].lsw[k]);
            chk($sformatf("v%0d_data1_b%0d", t, k), out_data1, tbl[t].msw[k]);
            chk($sformatf("v%0d_last_b%0d", t, k), out_last0, k == 3);
            chk($sformatf("v%0d_rdy_b%0d", t, k), in_ready0, k == 3);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        tbl[0].prod = 128'h0123456789ABCDEF_FEDCBA9876543210;
        tbl[0].lsw  = {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
        tbl[0].msw  = {32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567};
        tbl[1].prod = {128{1'b1}};
        tbl[1].lsw  = {4{32'hFFFFFFFF}};
        tbl[1].msw  = {4{32'hFFFFFFFF}};
        tbl[2].prod = 128'h0000000A_0000000B_0000000C_0000000D;
        tbl[2].lsw  = {32'h0000000A, 32'h0000000B, 32'h0000000C, 32'h0000000D};
        tbl[2].msw  = {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #12;
        // Reset state
        chk("rst_in_ready",  in_ready0,  1'b1);
        chk("rst_out_valid", out_valid0, 1'b0);
        chk("rst_out_last",  out_last0,  1'b0);
        chk("rst_out_data",  out_data0,  32'h0);
        chk("rst_busy",      busy0,      1'b0);
        chk("rst_out_data1", out_data1,  32'h0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // LSW/MSW ordering across the table
        for (int t = 0; t < 3; t++) send_vec(t);

        // Back-to-back: A accepted, B waits and is taken on A's last beat
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 128'h1;
        @(posedge clk); #1;
        in_data = 128'h2;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_valid_%0d", k), out_valid0, 1'b1);
            chk($sformatf("b2b_data0_%0d", k), out_data0,
                (k == 0) ? 32'h1 : (k == 4) ? 32'h2 : 32'h0);
            chk($sformatf("b2b_data1_%0d", k), out_data1,
                (k == 3) ? 32'h1 : (k == 7) ? 32'h2 : 32'h0);
            chk($sformatf("b2b_rdy_%0d", k), in_ready0, (k == 3) || (k == 7));
            if (k == 3) begin
                @(posedge clk); #1;
                in_valid = 1'b0; in_data = '0;
            end
        end
        @(posedge clk); #1;

        // Back-pressure on beat 1 for 3 cycles
        in_valid = 1'b1; in_data = tbl[0].prod;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_b0", out_data0, 32'h76543210);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_data_%0d", k), out_data0, 32'hFEDCBA98);
            chk($sformatf("bp_hold_vld_%0d", k), out_valid0, 1'b1);
            chk($sformatf("bp_hold_last_%0d", k), out_last0, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("bp_resume_%0d", k), out_data0, tbl[0].lsw[k]);
            chk($sformatf("bp_resume_last_%0d", k), out_last0, k == 3);
        end
        @(posedge clk); #1;

        // Asynchronous reset in the middle of beat 1
        in_valid = 1'b1; in_data = tbl[0].prod;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid0, 1'b0);
        chk("ar_out_last",  out_last0,  1'b0);
        chk("ar_busy",      busy0,      1'b0);
        chk("ar_in_ready",  in_ready0,  1'b1);
        chk("ar_busy1",     busy1,      1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_post_valid", out_valid0, 1'b0);
        send_vec(1);

        // Idle noise on in_data must not disturb anything
        for (int k = 0; k < 6; k++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk($sformatf("noise_vld_%0d", k), out_valid0, 1'b0);
            chk($sformatf("noise_busy_%0d", k), busy1, 1'b0);
            @(posedge clk); #1;
        end
        send_vec(2);

        // Randomized traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("drain_idle", busy0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/product_serializer.md
Name: product_serializer

Overview:
Downstream stage of the 64x64 multiplier. Captures each 128-bit registered product on a valid/ready handshake and emits it as a stream of narrower words with a last-beat flag. Width-adapts the multiplier result onto a 32-bit result bus, with back-pressure and back-to-back products at full throughput.

Parameters:
PROD_W, 128, product width; must be an integer multiple of WORD_W
WORD_W, 32, output word width
MSW_FIRST, 0, 0 = least-significant word first; 1 = most-significant word first

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  product on in_data is valid
in_ready  output  1  block accepts a product this cycle
in_data  input  PROD_W  product from the multiplier
out_valid  output  1  out_data holds a valid word
out_ready  input  1  consumer accepts the word this cycle
out_data  output  WORD_W  current word
out_last  output  1  current word is the final beat of its product
busy  output  1  a product is held or being sent

Behaviour:
- Derived constant: NBEATS = PROD_W/WORD_W (4 at defaults). Beat counter width = clog2(NBEATS), minimum 1.
- Reset (rst_n low, asynchronous): state=IDLE, beat counter=0, holding register=0. Outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0. Reset mid-product discards the partial product with no further beats.
- Input accept = in_valid & in_ready. Output accept = out_valid & out_ready.
- State IDLE: in_ready=1, out_valid=0. On input accept, latch in_data, clear the beat counter, go to SEND.
- State SEND: out_valid=1. out_data = word[beat] of the holding register, where word[i] = bits [i*WORD_W +: WORD_W]. Index is beat when MSW_FIRST=0 and NBEATS-1-beat when MSW_FIRST=1. out_last = (beat==NBEATS-1).
- SEND, output accept with out_last=0: beat increments.
- SEND, output accept with out_last=1: product is done.
  - If in_valid is also high the same cycle, accept it: latch the new in_data, set beat=0, stay in SEND. No bubble.
  - Otherwise go to IDLE.
- in_ready in SEND = out_valid & out_ready & out_last (combinational from out_ready). in_ready is 0 in every other SEND cycle.
- First word appears on out_data the cycle after input accept. Per-product occupancy is exactly NBEATS cycles when out_ready is held high.
- Stall: with out_ready=0, out_data, out_last and the beat counter hold stable. out_valid never deasserts while in SEND (AXI-stream rule).
- out_data is a mux of the holding register; no extra pipeline stage. Outside SEND it reads word 0 of the holding register and out_valid=0.
- busy = (state==SEND).
- Degenerate case NBEATS=1: every beat is last. The block acts as a 1-deep register slice with pass-through when out_ready=1.
- in_data is sampled only on input accept. Changes on in_data at other times have no effect.

Decomposition:
- Shared package mult_pkg holds PROD_W/WORD_W defaults, NBEATS derivation, the state encoding localparams (IDLE=1'b0, SEND=1'b1) and a clog2 function.
- Natural sub-module: word_mux, a parameterised combinational word selector (holding register, beat index, MSW_FIRST → out_data). It is reused by the planned operand deserializer upstream.
- Top-level FSM, counter and handshake logic stay in product_serializer.

Test Plan:
1. Defaults, product 0x0123456789ABCDEF_FEDCBA9876543210, out_ready=1 -> words 0x76543210, 0xFEDCBA98, 0x89ABCDEF, 0x01234567 on 4 consecutive cycles starting 1 cycle after accept; out_last only on the 4th; in_ready=0 for beats 1-3.
2. MSW_FIRST=1, same product -> order 0x01234567, 0x89ABCDEF, 0xFEDCBA98, 0x76543210; out_last on 0x76543210.
3. Back-to-back: in_valid held high with products 0x…0001 then 0x…0002 -> second accepted in the same cycle as the first product's last beat; 8 contiguous valid beats with no gap.
4. Back-pressure: out_ready low for 3 cycles during beat 1 -> out_data stays 0xFEDCBA98, out_valid stays 1, beat does not advance; stream resumes correctly afterwards.
5. Reset mid-product: assert rst_n=0 asynchronously after beat 1 -> out_valid, out_last, busy drop immediately; in_ready=1. After release, new product 0xFFFF…FFFF gives 4 beats of 0xFFFFFFFF.
6. Idle noise: in_data toggles with in_valid=0 -> out_valid stays 0 and busy stays 0; a later accepted product is emitted intact.
